// File: rtl/mac_sequencer_if.sv
// Bus between the sequencer (master) and one mac unit (slave): clear, enable,
// operand pair going in, accumulated value coming back.
interface mac_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                     mac_reset;
    logic                     mac_enable;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic signed [DATA_W-1:0] mac_out;

    modport master (output mac_reset, mac_enable, mac_a, mac_b, input  mac_out);
    modport slave  (input  mac_reset, mac_enable, mac_a, mac_b, output mac_out);
endinterface

// File: rtl/mac_sequencer.sv
// Dot-product job controller: buffers operand pairs, clears the mac, streams
// len pairs back-to-back, waits out the mac latency and captures the result.
module mac_sequencer #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_a,
    input  logic signed [DATA_W-1:0] wr_b,
    input  logic                     start,
    input  logic [ADDR_W:0]          len,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result,
    mac_sequencer_if.master          mac
);
    localparam int               CNT_W      = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L    = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [ADDR_W-1:0]        idx_reg, idx_next;
    logic [ADDR_W:0]          len_reg, len_next;
    logic [CNT_W-1:0]         drain_reg, drain_next;
    logic signed [DATA_W-1:0] result_reg, result_next;
    logic signed [DATA_W-1:0] a_reg, b_reg;

    logic signed [DATA_W-1:0] mem_a [DEPTH];
    logic signed [DATA_W-1:0] mem_b [DEPTH];

    logic            wr_ok;
    logic            rd_en;
    logic [ADDR_W:0] len_clamped;

    // Buffer is locked outside IDLE so a running job always sees a stable snapshot.
    assign wr_ok       = wr_en && (state_reg == ST_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign rd_en       = (state_next == ST_STREAM);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    // Read is issued one edge early (at idx_next) so the pair lands exactly in its STREAM cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (rd_en) begin
            a_reg <= mem_a[idx_next];
            b_reg <= mem_b[idx_next];
        end else begin
            a_reg <= '0;
            b_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            len_reg    <= '0;
            drain_reg  <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            len_reg    <= len_next;
            drain_reg  <= drain_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        drain_next  = drain_reg;
        result_next = result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next   = len_clamped;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                idx_next   = '0;
                drain_next = '0;
                state_next = (len_reg != '0) ? ST_STREAM : ST_DRAIN;
            end
            ST_STREAM: begin
                if ({1'b0, idx_reg} == len_reg - 1'b1) begin
                    idx_next   = '0;
                    state_next = ST_DRAIN;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    result_next = mac.mac_out;
                    drain_next  = '0;
                    state_next  = ST_DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_reg != ST_IDLE);
    assign done           = (state_reg == ST_DONE);
    assign result         = result_reg;
    assign mac.mac_reset  = reset || (state_reg == ST_CLEAR);
    assign mac.mac_enable = (state_reg == ST_STREAM);
    assign mac.mac_a      = a_reg;
    assign mac.mac_b      = b_reg;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a registered mac stand-in, a job-timeline
// model checked every cycle, and hand-computed literals per scenario.
module tb_mac_sequencer;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int LAT    = 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_a, wr_b;
    logic                     start;
    logic [ADDR_W:0]          len;
    logic                     busy, done;
    logic signed [DATA_W-1:0] result;

    mac_sequencer_if #(.DATA_W(DATA_W)) mbus ();

    mac_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAC_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .start(start), .len(len),
        .busy(busy), .done(done), .result(result), .mac(mbus.master)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Q1.7 product, arithmetic shift, truncated back to DATA_W
    function automatic logic signed [DATA_W-1:0] prod8(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        logic signed [2*DATA_W-1:0] s;
        p = a * b;
        s = p >>> (DATA_W - 1);
        return s[DATA_W-1:0];
    endfunction

    // Stand-in for the mac unit.
    logic signed [DATA_W-1:0] mac_acc;
    always @(posedge clk) begin
        if (mbus.mac_reset)       mac_acc <= '0;
        else if (mbus.mac_enable) mac_acc <= mac_acc + prod8(mbus.mac_a, mbus.mac_b);
    end
    assign mbus.mac_out = mac_acc;

    // Job model: t is the cycle index after the start edge (0 = clear, 1..L = pairs, L+LAT+1 = done).
    bit                       m_active = 1'b0;
    int                       m_t = 0;
    int                       m_len = 0;
    logic signed [DATA_W-1:0] m_buf_a [DEPTH];
    logic signed [DATA_W-1:0] m_buf_b [DEPTH];
    logic signed [DATA_W-1:0] m_snap_a [DEPTH];
    logic signed [DATA_W-1:0] m_snap_b [DEPTH];
    logic signed [DATA_W-1:0] m_result;

    function automatic logic signed [DATA_W-1:0] dot(input int n);
        logic signed [DATA_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < n; k++) acc = acc + prod8(m_snap_a[k], m_snap_b[k]);
        return acc;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_result = '0;
        end else if (!m_active) begin
            if (wr_en && int'(wr_addr) < DEPTH) begin
                m_buf_a[wr_addr] = wr_a;
                m_buf_b[wr_addr] = wr_b;
            end
            if (start) begin
                m_active = 1'b1;
                m_t      = 0;
                m_len    = (int'(len) > DEPTH) ? DEPTH : int'(len);
                m_snap_a = m_buf_a;
                m_snap_b = m_buf_b;
            end
        end else if (m_t == m_len + LAT + 1) begin
            m_active = 1'b0;
        end else begin
            m_t++;
            if (m_t == m_len + LAT + 1) m_result = dot(m_len);
        end
    end

    bit chk_on = 1'b0;
    int n_en, n_busy, n_mrst, n_done;

    always @(posedge clk) begin
        bit exp_en;
        #1;
        if (chk_on) begin
            exp_en = m_active && m_t >= 1 && m_t <= m_len;
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_active && m_t == m_len + LAT + 1));
            check("mac_reset", 32'(mbus.mac_reset), 32'(reset || (m_active && m_t == 0)));
            check("mac_enable", 32'(mbus.mac_enable), 32'(exp_en));
            if (exp_en) begin
                check("mac_a", mbus.mac_a, m_snap_a[m_t-1]);
                check("mac_b", mbus.mac_b, m_snap_b[m_t-1]);
            end else begin
                check("mac_a_idle", mbus.mac_a, 0);
                check("mac_b_idle", mbus.mac_b, 0);
            end
            check("result", result, m_result);
            if (mbus.mac_enable) n_en++;
            if (busy)            n_busy++;
            if (mbus.mac_reset)  n_mrst++;
            if (done)            n_done++;
        end
    end

    task automatic clear_counts();
        n_en = 0; n_busy = 0; n_mrst = 0; n_done = 0;
    endtask

    task automatic write_pair(input int addr, input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns the edge number (start edge = 0) that precedes the done cycle, or -1 on timeout.
    task automatic wait_done(input int first_edge, output int edge_no);
        bit seen;
        seen    = 1'b0;
        edge_no = first_edge - 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            edge_no = -1;
        end
        @(negedge clk);
    endtask

    task automatic run_job(input int l, output int lat);
        @(negedge clk);
        clear_counts();
        start = 1'b1; len = (ADDR_W + 1)'(l);
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
    endtask

    int lat;
    int idle_cycles;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; start = 1'b0; len = '0;
        clear_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", result, 0);
        check("rst_mac_reset", 32'(mbus.mac_reset), 1);
        check("rst_mac_enable", 32'(mbus.mac_enable), 0);
        check("rst_mac_a", mbus.mac_a, 0);
        chk_on = 1'b1;
        reset  = 1'b0;

        for (int k = 0; k < DEPTH; k++) write_pair(k, 8'sd64, 8'sd2);

        // 1: single pair
        write_pair(0, 8'sh71, 8'sh51);
        run_job(1, lat);
        $display("job len=1: done after edge %0d, result %0d, enables %0d", lat, result, n_en);
        check("t1_latency", lat, 3);
        check("t1_result", result, 71);
        check("t1_enables", n_en, 1);

        // 2: three pairs in address order
        write_pair(0, 8'sd64, 8'sd64);
        write_pair(1, 8'sd64, -8'sd64);
        write_pair(2, -8'sd128, 8'sd32);
        run_job(3, lat);
        $display("job len=3: done after edge %0d, result %0d, busy %0d cycles", lat, result, n_busy);
        check("t2_latency", lat, 5);
        check("t2_result", result, -32);
        check("t2_enables", n_en, 3);
        check("t2_busy_cycles", n_busy, 6);

        // 3: empty job, then an over-long job clamped to DEPTH
        run_job(0, lat);
        $display("job len=0: done after edge %0d, result %0d, mac_reset %0d", lat, result, n_mrst);
        check("t3_len0_latency", lat, 2);
        check("t3_len0_result", result, 0);
        check("t3_len0_mac_reset", n_mrst, 1);
        check("t3_len0_enables", n_en, 0);
        run_job(12, lat);
        $display("job len=12: done after edge %0d, result %0d, enables %0d", lat, result, n_en);
        check("t3_clamp_enables", n_en, 8);
        check("t3_clamp_latency", lat, 10);
        check("t3_clamp_result", result, -27);

        // 4: start and write while streaming are ignored
        @(negedge clk);
        clear_counts();
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_a = 8'sd1; wr_b = 8'sd1;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done(2, lat);
        $display("job len=3 disturbed: result %0d, enables %0d", result, n_en);
        check("t4_result", result, -32);
        check("t4_enables", n_en, 3);
        repeat (3) @(negedge clk);
        run_job(3, lat);
        $display("job len=3 rerun: result %0d", result);
        check("t4_rerun_result", result, -32);

        // 5: reset in the second stream cycle
        @(negedge clk);
        clear_counts();
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("reset mid-job: busy %0d, mac_enable %0d, result %0d", busy, mbus.mac_enable, result);
        check("t5_busy", 32'(busy), 0);
        check("t5_mac_enable", 32'(mbus.mac_enable), 0);
        check("t5_result", result, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_no_done", n_done, 0);
        run_job(3, lat);
        $display("job len=3 after reset: result %0d", result);
        check("t5_rerun_result", result, -32);

        // 6: start held high across two jobs
        @(negedge clk);
        clear_counts();
        start = 1'b1; len = 4'd3;
        wait_done(0, lat);
        len = 4'd1;
        $display("held start job 1: result %0d", result);
        check("t6_first_result", result, -32);
        idle_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (busy) break;
            idle_cycles++;
        end
        @(negedge clk);
        start = 1'b0;
        $display("held start: %0d idle cycle(s) between jobs", idle_cycles);
        check("t6_idle_gap", idle_cycles, 1);
        wait_done(0, lat);
        $display("held start job 2: result %0d", result);
        check("t6_second_result", result, 32);
        check("t6_done_pulses", n_done, 2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Initiator-side controller for the `mac` unit.
- Holds a small operand buffer that is loaded over a write port. On `start`, it clears the MAC, streams `len` operand pairs on consecutive cycles with `enable` high, waits out the MAC output latency, then captures the accumulated result and pulses `done`.
- Sits between the layer controller and one `mac` instance. It is the block that drives the `mac`'s `reset`/`enable`/`a`/`b` and reads its `out`.

Parameters:
- DEPTH, 8, number of operand-pair entries in the buffer.
- ADDR_W, 3, buffer address width; DEPTH <= 2**ADDR_W.
- DATA_W, 8, operand and result width; signed, Q1.7 when DATA_W=8.
- MAC_LATENCY, 1, cycles from the last enabled edge until `mac_out` is valid; must be >= 1.

Ports:
- clk, in, 1, system clock; all logic rising-edge.
- reset, in, 1, synchronous, active-high.
- wr_en, in, 1, write one operand pair into the buffer.
- wr_addr, in, ADDR_W, buffer write index.
- wr_a, in, DATA_W signed, operand A to store.
- wr_b, in, DATA_W signed, operand B to store.
- start, in, 1, begin a dot-product job (sampled in IDLE only).
- len, in, ADDR_W+1, number of pairs to stream, indices 0..len-1.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, single-cycle pulse; `result` is valid that cycle and is held after.
- result, out, DATA_W signed, captured MAC output.
- mac_reset, out, 1, drives `mac.reset`.
- mac_enable, out, 1, drives `mac.enable`.
- mac_a, out, DATA_W signed, drives `mac.a`.
- mac_b, out, DATA_W signed, drives `mac.b`.
- mac_out, in, DATA_W signed, from `mac.out`.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, mac_enable=0, mac_a=0, mac_b=0, idx=0, drain counter=0. `mac_reset`=1 while `reset` is high.
- The buffer memory is not reset; contents survive `reset`.
- `mac_reset` = `reset` OR (state==CLEAR).
- `mac_a`/`mac_b` equal the buffer entry at `idx` in STREAM and 0 in all other states.
- `mac_enable` = (state==STREAM).
- Writes:
  - `wr_en` is accepted only in IDLE. Writes in any other state are ignored, so the buffer is locked during a job.
  - A write and `start` in the same IDLE cycle: the write lands first, and the job sees the new data.
- Length handling:
  - `len` is latched on the start edge.
  - Values above DEPTH are clamped to DEPTH.
  - `len`=0 skips STREAM and yields result = MAC value after clear (0).
- FSM:
  - IDLE: on `start` -> CLEAR.
  - CLEAR: one cycle, `mac_reset`=1, idx=0. Next state is STREAM if len_q>0, else DRAIN.
  - STREAM: exactly len_q cycles, pairs idx=0..len_q-1 in order, no gaps. idx increments each cycle. After idx==len_q-1 -> DRAIN.
  - DRAIN: MAC_LATENCY cycles with `mac_enable`=0. On the final DRAIN edge, `result` <= `mac_out` -> DONE.
  - DONE: one cycle, `done`=1, `busy`=1 -> IDLE.
- Latency: with the start edge as edge 0, pair k is presented in the cycle after edge 1+k. `done` is high in the cycle after edge len+MAC_LATENCY+1. For the defaults with len=3, `done` follows edge 5.
- `start` while busy is ignored; it is not queued.
- `start` held high in DONE/IDLE: a new job begins on the first IDLE edge it is seen. Back-to-back jobs therefore have one IDLE cycle between them.
- `result` holds its value until the next DONE cycle. It is not cleared by `start`.
- Reset mid-job: on the next edge go to IDLE, busy=0, no `done` pulse, result=0. `mac_reset` is asserted for the reset cycles.
- No arithmetic is performed here. Overflow and saturation belong to `mac`; `result` is the raw captured `mac_out`.

Test Plan:
- Bench model: registered `mac` with `out` <= `reset`?0 : `enable`? `out`+((a*b)>>>7, truncated to DATA_W) : `out`.
1. Load (0x71,0x51) at addr 0, start with len=1 -> one STREAM cycle with mac_a=0x71, mac_b=0x51. `done` is high in the cycle after edge 3, with result = 113*81>>>7 = 71 (0x47).
2. Load (64,64),(64,-64),(-128,32) at addr 0..2, start len=3 -> `mac_enable` high for exactly 3 consecutive cycles, data in address order. Result = 32-32-32 = -32. `busy` is high for 6 cycles.
3. Start with len=0 -> `mac_reset` pulses once, no `mac_enable`, `done` with result=0. Then start with len=12 -> clamped, exactly 8 enabled cycles.
4. Mid-STREAM: pulse `start` and write addr 0 with (1,1) -> neither affects the job; result matches test 2. A re-run afterwards still sees the original addr-0 data.
5. `reset` asserted in the 2nd STREAM cycle -> next cycle `busy`=0, `mac_enable`=0, result=0, no `done`. A following job with len=3 reproduces -32.
6. Two jobs with `start` held high -> exactly one IDLE cycle between them. The first `done` shows the first result; `result` holds it until the second `done`.
